xmtr: RTL

Serial frame transmitter, the sending end of the header/body serial link whose receiver hunts for an 8-bit header and then shifts in a fixed-size body.
- Accepts body bytes from a local producer over a VALID/READY handshake into a collection buffer.
- Prepends HEADER_VALUE and shifts the frame out MSB-first on SDATA, one bit per SCLK.
- Double-buffered: the next frame's bytes can be collected while the current frame shifts, so back-to-back frames go out with no idle gap.

---
 rtl/xmtr.sv | 93 +++++++++
 1 files changed

// File: rtl/xmtr.sv
// Serial frame transmitter: collects BYTE_COUNT body bytes over VALID/READY,
// then shifts {HEADER_VALUE, body} out MSB-first on SDATA with double buffering.
//
// state | meaning
// IDLE  | no frame on SDATA, SDATA held at 0
// SEND  | shifting a frame out, bitcnt = index of bit currently on SDATA
module xmtr #(
    parameter int                     HEADER_SIZE  = 8,
    parameter logic [HEADER_SIZE-1:0] HEADER_VALUE = 8'ha5,
    parameter int                     BODY_SIZE    = 16,
    parameter int                     BYTE_COUNT   = 2,
    parameter int                     BCNT_SIZE    = 2,
    parameter int                     COUNTER_SIZE = 5
) (
    input  logic       SCLK,
    input  logic       RST,
    input  logic [7:0] DIN,
    input  logic       VALID,
    output logic       READY,
    output logic       BUSY,
    output logic       SDATA
);

    localparam int FRAME_SIZE = HEADER_SIZE + BODY_SIZE;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state, state_nxt;
    logic [BODY_SIZE-1:0]      buffer;
    logic [BCNT_SIZE-1:0]      bytecnt;
    logic [FRAME_SIZE-2:0]     shreg;
    logic [COUNTER_SIZE-1:0]   bitcnt;
    logic                      sdata_q;
    logic                      full;
    logic                      last_bit;
    logic                      load;

    assign full     = (bytecnt == BCNT_SIZE'(BYTE_COUNT));
    assign last_bit = (state == SEND) && (bitcnt == COUNTER_SIZE'(FRAME_SIZE - 1));
    assign load     = full && ((state == IDLE) || last_bit);

    assign READY = !full;
    assign BUSY  = (state == SEND);
    assign SDATA = sdata_q;

    always_ff @(posedge SCLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full) state_nxt = SEND;
            SEND:    if (last_bit && !full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Header MSB leaves on the load edge, so the shifter only keeps the remaining bits.
    always_ff @(posedge SCLK) begin
        if (RST) begin
            buffer  <= '0;
            bytecnt <= '0;
            shreg   <= '0;
            bitcnt  <= '0;
            sdata_q <= 1'b0;
        end else begin
            if (load)
                bytecnt <= '0;
            else if (VALID && READY) begin
                buffer  <= {buffer[BODY_SIZE-9:0], DIN};
                bytecnt <= bytecnt + BCNT_SIZE'(1);
            end

            if (load) begin
                shreg   <= {HEADER_VALUE[HEADER_SIZE-2:0], buffer};
                sdata_q <= HEADER_VALUE[HEADER_SIZE-1];
                bitcnt  <= '0;
            end else if (last_bit) begin
                sdata_q <= 1'b0;
                bitcnt  <= '0;
            end else if (state == SEND) begin
                sdata_q <= shreg[FRAME_SIZE-2];
                shreg   <= {shreg[FRAME_SIZE-3:0], 1'b0};
                bitcnt  <= bitcnt + COUNTER_SIZE'(1);
            end
        end
    end

endmodule
